// File: rtl/drag_velocity_pkg.sv
// Shared types and the output-width reduction helper for drag_velocity_est.
// The VEL_SAT_EN macro selects saturation instead of plain truncation in sat_trunc.
package drag_velocity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    PEND  = 2'd2
  } state_e;

  localparam int CALC_MAX_W = 64;

  // Reduces a wide signed value to out_w bits; result is returned sign-extended to 64 bits.
  function automatic logic signed [CALC_MAX_W-1:0] sat_trunc(
    input logic signed [CALC_MAX_W-1:0] value,
    input int                           out_w
  );
`ifdef VEL_SAT_EN
    logic signed [CALC_MAX_W-1:0] hi;
    logic signed [CALC_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
`else
    return (value <<< (CALC_MAX_W - out_w)) >>> (CALC_MAX_W - out_w);
`endif
  endfunction

endpackage

// File: rtl/velocity_history.sv
// DEPTH-deep circular buffer of {x,y} cursor samples with fill tracking and flush.
// Exposes the newest sample and the oldest one still inside the estimation window.
module velocity_history #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_x,
  input  logic [W-1:0]             wr_y,
  output logic [W-1:0]             newest_x,
  output logic [W-1:0]             newest_y,
  output logic [W-1:0]             oldest_x,
  output logic [W-1:0]             oldest_y,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [2*W-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  newest_ptr;
  logic [PW-1:0]  oldest_ptr;

  // NOTE: the sample storage has no reset; fill says which entries are meaningful,
  // so reset and flush only need to clear the pointer and fill count.
  always_ff @(posedge i_clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= {wr_x, wr_y};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Until the buffer is full the first sample sits at slot 0; once full, the slot about
  // to be overwritten is the one DEPTH-1 samples behind the newest.
  assign newest_ptr = wr_ptr - 1'b1;
  assign oldest_ptr = (fill == FULL) ? wr_ptr : '0;

  assign {newest_x, newest_y} = mem[newest_ptr];
  assign {oldest_x, oldest_y} = mem[oldest_ptr];

endmodule

// File: rtl/drag_velocity_est.sv
// Drag/throw velocity estimator: samples the cursor while the button is held and offers
// latched x/y/z launch velocities on release. Define VEL_SAT_EN to saturate outputs.
module drag_velocity_est
  import drag_velocity_pkg::*;
#(
  parameter int W          = 16,
  parameter int OUT_W      = 16,
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DIV = 4,
  parameter int X_SHR      = 0,
  parameter int Y_SHR      = 1,
  parameter int Z_SHL      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_mouse_left,
  input  logic [W-1:0]            i_mouse_x,
  input  logic [W-1:0]            i_mouse_y,
  output logic signed [OUT_W-1:0] o_x_vel,
  output logic signed [OUT_W-1:0] o_y_vel,
  output logic signed [OUT_W-1:0] o_z_vel,
  output logic                    o_throw_valid,
  input  logic                    i_throw_ack
);

  localparam int          CW       = W + Z_SHL + 2;
  localparam int          PW       = $clog2(DEPTH);
  localparam int          CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [PW:0]      FILL_MIN = (PW+1)'(2);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              hist_flush;
  logic              capture;
  logic [W-1:0]      newest_x, newest_y, oldest_x, oldest_y;
  logic [PW:0]       fill;

  logic signed [W:0]       dx, dy;
  logic signed [CW-1:0]    dx_w, dy_w, vx_c, vy_c, vz_c;
  logic signed [OUT_W-1:0] vx_n, vy_n, vz_n;

  // The history is emptied on a clear and whenever a new drag starts.
  assign hist_flush = i_clear || (state == IDLE && i_mouse_left);
  assign capture    = !i_clear && state == TRACK && i_mouse_left && cnt == '0;

  velocity_history #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_history (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .flush    (hist_flush),
    .wr_en    (capture),
    .wr_x     (i_mouse_x),
    .wr_y     (i_mouse_y),
    .newest_x (newest_x),
    .newest_y (newest_y),
    .oldest_x (oldest_x),
    .oldest_y (oldest_y),
    .fill     (fill)
  );

  always_comb begin
    // NOTE: every variable gets a default before the if, so no latch is inferred.
    dx = '0;
    dy = '0;
    if (fill >= FILL_MIN) begin
      dx = $signed({1'b0, newest_x}) - $signed({1'b0, oldest_x});
      dy = $signed({1'b0, newest_y}) - $signed({1'b0, oldest_y});
    end
  end

  // Widen before shifting so the z left shift cannot overflow ahead of the output reduction.
  assign dx_w = CW'(dx);
  assign dy_w = CW'(dy);
  assign vx_c = dx_w >>> X_SHR;
  assign vy_c = dy_w >>> Y_SHR;
  assign vz_c = dy_w <<< Z_SHL;

  assign vx_n = OUT_W'(sat_trunc(64'(vx_c), OUT_W));
  assign vy_n = OUT_W'(sat_trunc(64'(vy_c), OUT_W));
  assign vz_n = OUT_W'(sat_trunc(64'(vz_c), OUT_W));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      o_x_vel       <= '0;
      o_y_vel       <= '0;
      o_z_vel       <= '0;
      o_throw_valid <= 1'b0;
    end else if (i_clear) begin
      state         <= IDLE;
      cnt           <= '0;
      o_x_vel       <= '0;
      o_y_vel       <= '0;
      o_z_vel       <= '0;
      o_throw_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_mouse_left) begin
            state <= TRACK;
            cnt   <= '0;
          end
        end

        TRACK: begin
          if (!i_mouse_left) begin
            if (fill >= FILL_MIN) begin
              state         <= PEND;
              o_throw_valid <= 1'b1;
              o_x_vel       <= vx_n;
              o_y_vel       <= vy_n;
              o_z_vel       <= vz_n;
            end else begin
              state   <= IDLE;
              o_x_vel <= '0;
              o_y_vel <= '0;
              o_z_vel <= '0;
            end
          end else begin
            cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            o_x_vel <= vx_n;
            o_y_vel <= vy_n;
            o_z_vel <= vz_n;
          end
        end

        PEND: begin
          // Button activity is ignored here; only the consumer's ack releases the throw.
          if (i_throw_ack) begin
            state         <= IDLE;
            o_throw_valid <= 1'b0;
            o_x_vel       <= '0;
            o_y_vel       <= '0;
            o_z_vel       <= '0;
          end
        end

        default: begin
          state         <= IDLE;
          o_throw_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
